// File: rtl/tetris_pkg.sv
// tetris_pkg: shared board defaults, FSM state encoding, rotation directions and popcount.
package tetris_pkg;
    localparam int ROWS_DEF = 12;
    localparam int COLS_DEF = 12;
    localparam logic DIR_CW = 1'b0;
    localparam logic DIR_CCW = 1'b1;
    typedef enum logic [1:0] {IDLE, MAP, CHECK} state_t;
    // Rows wider than 64 columns are not supported.
    function automatic logic [6:0] popcount(input logic [63:0] v);
        popcount = '0;
        for (int i = 0; i < 64; i++) popcount += 7'(v[i]);
    endfunction
endpackage

// File: rtl/piece_rotator_if.sv
// piece_rotator_if: request/result bundle between the game-control FSM and the piece rotator.
interface piece_rotator_if #(
    parameter int ROWS = tetris_pkg::ROWS_DEF,
    parameter int COLS = tetris_pkg::COLS_DEF,
    parameter int PT_W = 10
);
    logic start;
    logic dir;
    logic [PT_W-1:0] centralPoint;
    logic [ROWS*COLS-1:0] backGround;
    logic [ROWS*COLS-1:0] currentSqs;
    logic busy;
    logic done;
    logic canRotate;
    logic [ROWS*COLS-1:0] newSqs;
    logic [1:0] kickOffset;
    modport master (output start, dir, centralPoint, backGround, currentSqs,
                    input busy, done, canRotate, newSqs, kickOffset);
    modport slave (input start, dir, centralPoint, backGround, currentSqs,
                   output busy, done, canRotate, newSqs, kickOffset);
endinterface

// File: rtl/rot_row_mapper.sv
// rot_row_mapper: builds one destination row of the rotated piece by inverse-mapping each column to its source cell.
module rot_row_mapper import tetris_pkg::*; #(
    parameter int ROWS = ROWS_DEF,
    parameter int COLS = COLS_DEF,
    parameter int PT_W = 10
) (
    input  logic dir,
    input  logic [PT_W-1:0] rx,
    input  logic [PT_W-1:0] ry,
    input  logic signed [1:0] k,
    input  logic [PT_W-1:0] row,
    input  logic [ROWS*COLS-1:0] srcSqs,
    output logic [COLS-1:0] dstRow
);
    localparam int W = PT_W + 2;
    localparam int IW = $clog2(ROWS * COLS);
    logic signed [W-1:0] dx, dy, sr, sc;
    logic [IW-1:0] idx;
    always_comb begin
        dstRow = '0;
        dy = '0;
        sr = '0;
        sc = '0;
        idx = '0;
        dx = $signed({2'b00, row}) - $signed({2'b00, rx});
        for (int c = 0; c < COLS; c++) begin
            dy = W'(c) - W'(k) - $signed({2'b00, ry});
            sc = (dir == DIR_CW) ? $signed({2'b00, ry}) + dx : $signed({2'b00, ry}) - dx;
            sr = (dir == DIR_CW) ? $signed({2'b00, rx}) - dy : $signed({2'b00, rx}) + dy;
            idx = IW'(sr * COLS + sc);
            // Sources off the board read as empty, so lost cells show up as a count deficit.
            dstRow[c] = !sr[W-1] && !sc[W-1] && sr < W'(ROWS) && sc < W'(COLS) && srcSqs[idx];
        end
    end
endmodule

// File: rtl/piece_rotator.sv
// piece_rotator: multi-cycle rotation of the active piece about a pivot with collision/off-board rejection.
// Defining WALL_KICK_EN retries a rejected rotation with column kicks of -1 then +1.
module piece_rotator import tetris_pkg::*; #(
    parameter int ROWS = ROWS_DEF,
    parameter int COLS = COLS_DEF,
    parameter int PT_W = 10
) (
    input logic clk,
    input logic resetn,
    piece_rotator_if.slave bus
);
    localparam int N = ROWS * COLS;
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(N + 1);
`ifdef WALL_KICK_EN
    localparam bit KICK_EN = 1'b1;
`else
    localparam bit KICK_EN = 1'b0;
`endif
    state_t state;
    logic dirL, overlap, badPivot, ok;
    logic [PT_W-1:0] cpL, rowIdx, rx, ry;
    logic [N-1:0] bgL, srcL, image;
    logic [CW-1:0] cntNew, cntOld;
    logic signed [1:0] kick;
    logic [COLS-1:0] mapped;
    logic [IW-1:0] base;
    assign rx = PT_W'(cpL / COLS);
    assign ry = PT_W'(cpL % COLS);
    assign base = IW'(rowIdx * COLS);
    assign badPivot = cpL >= PT_W'(N);
    assign ok = !badPivot && !overlap && cntNew == cntOld;
    rot_row_mapper #(.ROWS(ROWS), .COLS(COLS), .PT_W(PT_W)) mapper (
        .dir(dirL), .rx(rx), .ry(ry), .k(kick), .row(rowIdx), .srcSqs(srcL), .dstRow(mapped)
    );
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.canRotate <= 1'b0;
            bus.newSqs <= '0;
            bus.kickOffset <= '0;
            dirL <= 1'b0;
            cpL <= '0;
            bgL <= '0;
            srcL <= '0;
            image <= '0;
            rowIdx <= '0;
            overlap <= 1'b0;
            cntNew <= '0;
            cntOld <= '0;
            kick <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: if (bus.start && !bus.done) begin
                    dirL <= bus.dir;
                    cpL <= bus.centralPoint;
                    bgL <= bus.backGround;
                    srcL <= bus.currentSqs;
                    rowIdx <= '0;
                    overlap <= 1'b0;
                    cntNew <= '0;
                    cntOld <= '0;
                    kick <= '0;
                    bus.busy <= 1'b1;
                    state <= (bus.centralPoint >= PT_W'(N)) ? CHECK : MAP;
                end
                MAP: begin
                    image[base +: COLS] <= mapped;
                    overlap <= overlap | (|(mapped & bgL[base +: COLS]));
                    cntNew <= cntNew + CW'(popcount(64'(mapped)));
                    cntOld <= cntOld + CW'(popcount(64'(srcL[base +: COLS])));
                    rowIdx <= rowIdx + 1'b1;
                    if (rowIdx == PT_W'(ROWS - 1)) state <= CHECK;
                end
                CHECK: if (KICK_EN && !ok && !badPivot && kick != 2'sd1) begin
                    // Kick order is 0, -1, +1.
                    kick <= (kick == 2'sd0) ? -2'sd1 : 2'sd1;
                    rowIdx <= '0;
                    overlap <= 1'b0;
                    cntNew <= '0;
                    cntOld <= '0;
                    state <= MAP;
                end else begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b1;
                    bus.canRotate <= ok;
                    bus.newSqs <= ok ? image : srcL;
                    bus.kickOffset <= ok ? kick : 2'sd0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_piece_rotator.sv
// tb_piece_rotator: randomized and directed checks of piece_rotator against a forward-mapping reference model.
// Expectations follow WALL_KICK_EN when the bench is built with it.
module tb_piece_rotator;
    localparam int ROWS = 12;
    localparam int COLS = 12;
    localparam int PT_W = 10;
    localparam int N = ROWS * COLS;
`ifdef WALL_KICK_EN
    localparam bit KICK = 1'b1;
`else
    localparam bit KICK = 1'b0;
`endif
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int tests = 0;
    int fails = 0;

    piece_rotator_if #(.ROWS(ROWS), .COLS(COLS), .PT_W(PT_W)) bus();
    piece_rotator #(.ROWS(ROWS), .COLS(COLS), .PT_W(PT_W)) dut (.clk(clk), .resetn(resetn), .bus(bus.slave));

    always #5 clk = ~clk;

    function automatic logic [N-1:0] cells(input int a, input int b, input int c, input int d);
        logic [N-1:0] v;
        v = '0;
        if (a >= 0) v[a] = 1'b1;
        if (b >= 0) v[b] = 1'b1;
        if (c >= 0) v[c] = 1'b1;
        if (d >= 0) v[d] = 1'b1;
        return v;
    endfunction

    // Reference: move every set cell forward with the rotation formula; any lost or colliding cell rejects.
    task automatic ref_model(input logic d, input int cp, input logic [N-1:0] bg, input logic [N-1:0] cur,
                             output logic can, output logic [N-1:0] res, output logic [1:0] kk, output int lat);
        int ks[3];
        int rx, ry, sr, sc, dr, dc;
        bit good;
        logic [N-1:0] img;
        ks[0] = 0; ks[1] = -1; ks[2] = 1;
        can = 1'b0; res = cur; kk = 2'b00;
        if (cp >= N) begin
            lat = 2;
            return;
        end
        rx = cp / COLS; ry = cp % COLS;
        lat = 1;
        for (int t = 0; t < (KICK ? 3 : 1); t++) begin
            img = '0; good = 1'b1;
            lat += ROWS + 1;
            for (int i = 0; i < N; i++) begin
                if (cur[i]) begin
                    sr = i / COLS; sc = i % COLS;
                    dr = d ? rx - (sc - ry) : rx + (sc - ry);
                    dc = d ? ry + (sr - rx) + ks[t] : ry - (sr - rx) + ks[t];
                    if (dr < 0 || dr >= ROWS || dc < 0 || dc >= COLS) good = 1'b0;
                    else if (bg[dr*COLS+dc]) good = 1'b0;
                    else img[dr*COLS+dc] = 1'b1;
                end
            end
            if (good) begin
                can = 1'b1; res = img; kk = 2'(ks[t]);
                return;
            end
        end
    endtask

    // Issues one request from idle and returns the result; ends one cycle after done so the next request is accepted.
    task automatic run_req(input logic d, input int cp, input logic [N-1:0] bg, input logic [N-1:0] cur,
                           output logic can, output logic [N-1:0] res, output logic [1:0] kk,
                           output int lat, output bit busyOk);
        bus.dir = d; bus.centralPoint = PT_W'(cp); bus.backGround = bg; bus.currentSqs = cur; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = -1; busyOk = 1'b1;
        for (int n = 1; n <= 200; n++) begin
            if (bus.done) begin
                lat = n;
                break;
            end
            if (bus.busy !== 1'b1) busyOk = 1'b0;
            @(posedge clk); #1;
        end
        if (bus.busy !== 1'b0) busyOk = 1'b0;
        can = bus.canRotate; res = bus.newSqs; kk = bus.kickOffset;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.dir = 1'b0; bus.centralPoint = '0; bus.backGround = '0; bus.currentSqs = '0;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", bus.done); end
        tests++; if (bus.canRotate !== 1'b0) begin fails++; $display("FAIL reset_can got %b want 0", bus.canRotate); end
        tests++; if (bus.newSqs !== '0) begin fails++; $display("FAIL reset_newSqs got %h want 0", bus.newSqs); end
        tests++; if (bus.kickOffset !== 2'b00) begin fails++; $display("FAIL reset_kick got %b want 00", bus.kickOffset); end
        resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_vectors();
        logic [N-1:0] cur[6], bg[6], wantNew[6], res;
        logic d[6], wantCan[6], can;
        logic [1:0] wantKick[6], kk;
        int cp[6], wantLat[6], lat;
        bit busyOk;
        cur[0] = cells(64, 65, 66, 67); bg[0] = '0; cp[0] = 65; d[0] = 0;
        wantCan[0] = 1; wantNew[0] = cells(53, 65, 77, 89); wantKick[0] = 0; wantLat[0] = 14;
        cur[1] = cur[0]; bg[1] = cells(77, -1, -1, -1); cp[1] = 65; d[1] = 0;
        wantCan[1] = KICK; wantNew[1] = KICK ? cells(52, 64, 76, 88) : cur[0];
        wantKick[1] = KICK ? 2'b11 : 2'b00; wantLat[1] = KICK ? 27 : 14;
        cur[2] = cells(0, 1, -1, -1); bg[2] = '0; cp[2] = 0; d[2] = 1;
        wantCan[2] = 0; wantNew[2] = cur[2]; wantKick[2] = 0; wantLat[2] = KICK ? 40 : 14;
        cur[3] = cur[2]; bg[3] = '0; cp[3] = 0; d[3] = 0;
        wantCan[3] = 1; wantNew[3] = cells(0, 12, -1, -1); wantKick[3] = 0; wantLat[3] = 14;
        cur[4] = cells(53, 65, 77, 89); bg[4] = '0; cp[4] = 65; d[4] = 1;
        wantCan[4] = 1; wantNew[4] = cells(64, 65, 66, 67); wantKick[4] = 0; wantLat[4] = 14;
        cur[5] = cells(59, 71, 83, 95); bg[5] = '0; cp[5] = 71; d[5] = 0;
        wantCan[5] = KICK; wantNew[5] = KICK ? cells(68, 69, 70, 71) : cur[5];
        wantKick[5] = KICK ? 2'b11 : 2'b00; wantLat[5] = KICK ? 27 : 14;
        for (int v = 0; v < 6; v++) begin
            run_req(d[v], cp[v], bg[v], cur[v], can, res, kk, lat, busyOk);
            tests++; if (lat !== wantLat[v]) begin fails++; $display("FAIL vec%0d_latency got %0d want %0d", v, lat, wantLat[v]); end
            tests++; if (can !== wantCan[v]) begin fails++; $display("FAIL vec%0d_canRotate got %b want %b", v, can, wantCan[v]); end
            tests++; if (res !== wantNew[v]) begin fails++; $display("FAIL vec%0d_newSqs got %h want %h", v, res, wantNew[v]); end
            tests++; if (kk !== wantKick[v]) begin fails++; $display("FAIL vec%0d_kick got %b want %b", v, kk, wantKick[v]); end
            tests++; if (!busyOk) begin fails++; $display("FAIL vec%0d_busy got irregular busy want high until done", v); end
        end
    endtask

    task automatic test_random();
        logic [N-1:0] cur, bg, res, mRes;
        logic d, can, mCan;
        logic [1:0] kk, mKick;
        int cp, lat, mLat, r, c;
        bit busyOk;
        for (int t = 0; t < 60; t++) begin
            d = 1'($urandom_range(0, 1));
            cp = ($urandom_range(0, 15) == 0) ? int'($urandom_range(N, 1023)) : int'($urandom_range(0, N - 1));
            cur = '0;
            if ($urandom_range(0, 11) != 0) begin
                for (int j = 0; j < 4; j++) begin
                    r = (cp % N) / COLS + int'($urandom_range(0, 4)) - 2;
                    c = (cp % N) % COLS + int'($urandom_range(0, 4)) - 2;
                    if (r >= 0 && r < ROWS && c >= 0 && c < COLS) cur[r*COLS+c] = 1'b1;
                end
            end
            for (int i = 0; i < N; i++) bg[i] = ($urandom_range(0, 9) == 0);
            ref_model(d, cp, bg, cur, mCan, mRes, mKick, mLat);
            run_req(d, cp, bg, cur, can, res, kk, lat, busyOk);
            tests++;
            if (lat !== mLat || can !== mCan || res !== mRes || kk !== mKick || !busyOk) begin
                fails++;
                $display("FAIL rand%0d got lat=%0d can=%b kick=%b busyOk=%0d new=%h want lat=%0d can=%b kick=%b new=%h",
                         t, lat, can, kk, busyOk, res, mLat, mCan, mKick, mRes);
            end
        end
    endtask

    task automatic test_control();
        logic [N-1:0] res, mRes, cur;
        logic can, mCan;
        logic [1:0] kk, mKick;
        int lat, mLat, n1, n2, n;
        bit busyOk, sawDone, sawBusy;
        cur = cells(64, 65, 66, 67);
        run_req(0, 144, '0, cur, can, res, kk, lat, busyOk);
        tests++; if (lat !== 2) begin fails++; $display("FAIL badpivot_latency got %0d want 2", lat); end
        tests++; if (can !== 1'b0 || res !== cur) begin fails++; $display("FAIL badpivot_result got can=%b new=%h want can=0 new=%h", can, res, cur); end
        // Start pulses while busy must neither disturb the request nor queue a second one.
        ref_model(0, 65, '0, cur, mCan, mRes, mKick, mLat);
        bus.dir = 0; bus.centralPoint = 65; bus.backGround = '0; bus.currentSqs = cur; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = -1;
        for (n = 1; n <= 100; n++) begin
            if (bus.done) begin lat = n; break; end
            bus.start = (n >= 3 && n <= 5);
            bus.dir = 1; bus.centralPoint = 10; bus.currentSqs = cells(0, 1, 2, 3);
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        tests++; if (lat !== mLat || bus.newSqs !== mRes) begin fails++; $display("FAIL busy_start got lat=%0d new=%h want lat=%0d new=%h", lat, bus.newSqs, mLat, mRes); end
        sawBusy = 1'b0; sawDone = 1'b0;
        repeat (ROWS + 4) begin
            @(posedge clk); #1;
            if (bus.busy) sawBusy = 1'b1;
            if (bus.done) sawDone = 1'b1;
        end
        tests++; if (sawBusy || sawDone) begin fails++; $display("FAIL busy_start_queued got busy=%0d done=%0d want 0 0", sawBusy, sawDone); end
        // Asynchronous reset in cycle 5 aborts with no done pulse.
        bus.dir = 0; bus.centralPoint = 65; bus.currentSqs = cur; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        tests++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin fails++; $display("FAIL midreset got busy=%b done=%b want 0 0", bus.busy, bus.done); end
        @(posedge clk); #1;
        resetn = 1'b1;
        sawDone = 1'b0;
        repeat (ROWS + 4) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) sawDone = 1'b1;
        end
        tests++; if (sawDone) begin fails++; $display("FAIL midreset_activity got activity=1 want 0"); end
        // Start held high: the next request is taken the cycle after done.
        bus.start = 1'b1;
        n1 = -1; n2 = -1;
        for (n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            if (bus.done && n1 < 0) n1 = n;
            else if (bus.done) begin n2 = n; break; end
        end
        bus.start = 1'b0;
        @(posedge clk); #1;
        tests++; if (n1 !== 14 || n2 !== 29) begin fails++; $display("FAIL held_start got done at %0d,%0d want 14,29", n1, n2); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL held_start_release got busy=%b want 0", bus.busy); end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_random();
        test_control();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
